npu_inst_fetch: RTL and testbench



---
 rtl/npu_inst_fetch_if.sv | 39 +++
 rtl/npu_inst_fetch.sv | 95 +++++++++
 tb/tb_npu_inst_fetch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/npu_inst_fetch_if.sv
// npu_inst_fetch_if: command, SRAM port-2 and decoder-stream signals of the instruction fetch stage.
// Ports (master = fetch stage side):
//   start/start_addr/inst_count       command from the sequencer
//   sram_*2                           read-only SRAM port 2 (1-cycle read latency)
//   inst_valid/inst_ready/inst_data/inst_addr  stream to the decoder
//   busy/done                         status
interface npu_inst_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
);
    logic                  start;
    logic [ADDR_W-1:0]     start_addr;
    logic [ADDR_W:0]       inst_count;
    logic [ADDR_W-1:0]     sram_address2;
    logic                  sram_chipselect2;
    logic                  sram_clken2;
    logic                  sram_write2;
    logic [DATA_W/8-1:0]   sram_byteenable2;
    logic [DATA_W-1:0]     sram_writedata2;
    logic [DATA_W-1:0]     sram_readdata2;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_W-1:0]     inst_data;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  busy;
    logic                  done;
    modport master (
        input  start, start_addr, inst_count, sram_readdata2, inst_ready,
        output sram_address2, sram_chipselect2, sram_clken2, sram_write2,
               sram_byteenable2, sram_writedata2, inst_valid, inst_data,
               inst_addr, busy, done
    );
    modport slave (
        output start, start_addr, inst_count, sram_readdata2, inst_ready,
        input  sram_address2, sram_chipselect2, sram_clken2, sram_write2,
               sram_byteenable2, sram_writedata2, inst_valid, inst_data,
               inst_addr, busy, done
    );
endinterface

// File: rtl/npu_inst_fetch.sv
// npu_inst_fetch: streams a contiguous run of SRAM instruction words through a small FIFO to the decoder.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    npu_inst_fetch_if.master: start command, SRAM port-2 reads, valid/ready
//          instruction stream tagged with its SRAM address, busy/done status
module npu_inst_fetch #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    npu_inst_fetch_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 2;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;
    state_t            r_state, w_next_state;
    logic [ADDR_W-1:0] r_next_addr, r_inflight_addr;
    logic [ADDR_W:0]   r_issue_left, r_accept_left;
    logic              r_inflight;
    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [CW-1:0]     w_used;
    logic              w_issue, w_pop, w_valid, w_load;
    assign w_valid = r_count != '0;
    assign w_pop   = w_valid && bus.inst_ready;
    assign w_load  = (r_state == IDLE) && bus.start;
    // Credit counts the registered occupancy plus the read in flight, so a
    // same-cycle pop never lets a new read overrun the FIFO.
    assign w_used  = CW'(r_count) + CW'(r_inflight);
    assign w_issue = (r_state == FETCH) && (r_issue_left != '0) && (w_used < CW'(FIFO_DEPTH));
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  w_next_state = bus.start ? ((bus.inst_count == '0) ? FIN : FETCH) : IDLE;
            FETCH: w_next_state = (w_issue && r_issue_left == (ADDR_W+1)'(1)) ? DRAIN : FETCH;
            DRAIN: w_next_state = (w_pop && r_accept_left == (ADDR_W+1)'(1)) ? FIN : DRAIN;
            FIN:   w_next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_next_addr     <= '0;
            r_inflight_addr <= '0;
            r_issue_left    <= '0;
            r_accept_left   <= '0;
            r_inflight      <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
        end else begin
            r_state    <= w_next_state;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_addr <= r_next_addr;
                r_next_addr     <= r_next_addr + ADDR_W'(1);
                r_issue_left    <= r_issue_left - (ADDR_W+1)'(1);
            end
            if (w_load) begin
                r_next_addr   <= bus.start_addr;
                r_issue_left  <= bus.inst_count;
                r_accept_left <= bus.inst_count;
            end
            if (w_pop) begin
                r_accept_left <= r_accept_left - (ADDR_W+1)'(1);
                r_rd_ptr      <= r_rd_ptr + PTR_W'(1);
            end
            if (r_inflight) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(r_inflight) - (PTR_W+1)'(w_pop);
        end
    end
    // The read issued last cycle returns now; capture it with its address.
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_mem_data[r_wr_ptr] <= bus.sram_readdata2;
            r_mem_addr[r_wr_ptr] <= r_inflight_addr;
        end
    end
    assign bus.sram_address2    = r_next_addr;
    assign bus.sram_chipselect2 = w_issue;
    assign bus.sram_clken2      = 1'b1;
    assign bus.sram_write2      = 1'b0;
    assign bus.sram_byteenable2 = '1;
    assign bus.sram_writedata2  = '0;
    assign bus.inst_valid       = w_valid;
    assign bus.inst_data        = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign bus.inst_addr        = w_valid ? r_mem_addr[r_rd_ptr] : '0;
    assign bus.busy             = r_state != IDLE;
    assign bus.done             = r_state == FIN;
endmodule

// File: tb/tb_npu_inst_fetch.sv
// tb_npu_inst_fetch: directed scoreboard bench for the instruction fetch stage.
module tb_npu_inst_fetch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    logic [7:0] rd_q[$];
    logic [7:0] acc_q[$];
    npu_inst_fetch_if #(.ADDR_W(8), .DATA_W(128)) bus();
    npu_inst_fetch #(.ADDR_W(8), .DATA_W(128), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [127:0] word(input logic [7:0] a);
        return {a, ~a, 16'hC0DE, 32'(a) * 32'd2654435761, 32'hA5A50000 | 32'(a), 32'(~a)};
    endfunction
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // SRAM port 2 model: one-cycle read latency.
    always @(posedge clk) if (bus.sram_chipselect2) bus.sram_readdata2 <= word(bus.sram_address2);
    // Monitors sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.sram_chipselect2) begin
                rd_cnt++;
                chk("rd_pending", 128'(rd_q.size() != 0), 128'(1));
                if (rd_q.size() != 0) chk("rd_addr", 128'(bus.sram_address2), 128'(rd_q.pop_front()));
            end
            if (bus.inst_valid && bus.inst_ready) begin
                acc_cnt++;
                chk("acc_pending", 128'(acc_q.size() != 0), 128'(1));
                if (acc_q.size() != 0) begin
                    automatic logic [7:0] a = acc_q.pop_front();
                    chk("acc_addr", 128'(bus.inst_addr), 128'(a));
                    chk("acc_data", bus.inst_data, word(a));
                end
            end
            if (bus.done) done_cnt++;
        end
    end
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic launch(input logic [7:0] a, input logic [8:0] n);
        for (int i = 0; i < int'(n); i++) begin
            rd_q.push_back(a + 8'(i));
            acc_q.push_back(a + 8'(i));
        end
        bus.start = 1'b1;
        bus.start_addr = a;
        bus.inst_count = n;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic wait_idle(input int budget, input bit rnd);
        int t = 0;
        while (bus.busy && t < budget) begin
            if (rnd) begin
                bus.inst_ready = 1'($urandom_range(0, 1));
                if (t % 37 == 5) begin
                    bus.start = 1'b1;
                    bus.start_addr = 8'h77;
                    bus.inst_count = 9'd5;
                end
            end
            tick();
            bus.start = 1'b0;
            t++;
        end
        chk("idle_timeout", 128'(bus.busy), 128'(0));
    endtask
    initial begin
        int r0, a0, d0;
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.inst_count = '0;
        bus.inst_ready = 1'b0;
        tick(2);
        chk("rst_addr", 128'(bus.sram_address2), 128'(0));
        chk("rst_cs", 128'(bus.sram_chipselect2), 128'(0));
        chk("rst_valid", 128'(bus.inst_valid), 128'(0));
        chk("rst_data", bus.inst_data, 128'(0));
        chk("rst_iaddr", 128'(bus.inst_addr), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        reset = 1'b0;
        tick();
        // Basic run
        bus.inst_ready = 1'b1;
        d0 = done_cnt;
        launch(8'h10, 9'd3);
        chk("b_cs0", 128'(bus.sram_chipselect2), 128'(1));
        chk("b_a0", 128'(bus.sram_address2), 128'(8'h10));
        chk("b_v0", 128'(bus.inst_valid), 128'(0));
        chk("b_busy", 128'(bus.busy), 128'(1));
        tick();
        chk("b_cs1", 128'(bus.sram_chipselect2), 128'(1));
        chk("b_a1", 128'(bus.sram_address2), 128'(8'h11));
        chk("b_v1", 128'(bus.inst_valid), 128'(0));
        tick();
        chk("b_cs2", 128'(bus.sram_chipselect2), 128'(1));
        chk("b_a2", 128'(bus.sram_address2), 128'(8'h12));
        chk("b_v2", 128'(bus.inst_valid), 128'(1));
        chk("b_head", 128'(bus.inst_addr), 128'(8'h10));
        tick();
        chk("b_cs3", 128'(bus.sram_chipselect2), 128'(0));
        tick(2);
        chk("b_done", 128'(bus.done), 128'(1));
        chk("b_done_busy", 128'(bus.busy), 128'(1));
        tick();
        chk("b_done_end", 128'(bus.done), 128'(0));
        chk("b_idle", 128'(bus.busy), 128'(0));
        chk("b_done_cnt", 128'(done_cnt - d0), 128'(1));
        chk("b_acc_left", 128'(acc_q.size()), 128'(0));
        // Backpressure
        bus.inst_ready = 1'b0;
        r0 = rd_cnt;
        a0 = acc_cnt;
        d0 = done_cnt;
        launch(8'h40, 9'd10);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.inst_valid) begin
                chk("bp_hold_addr", 128'(bus.inst_addr), 128'(8'h40));
                chk("bp_hold_data", bus.inst_data, word(8'h40));
            end
        end
        chk("bp_reads", 128'(rd_cnt - r0), 128'(4));
        chk("bp_cs_off", 128'(bus.sram_chipselect2), 128'(0));
        chk("bp_valid", 128'(bus.inst_valid), 128'(1));
        bus.inst_ready = 1'b1;
        wait_idle(200, 1'b0);
        chk("bp_acc", 128'(acc_cnt - a0), 128'(10));
        chk("bp_done", 128'(done_cnt - d0), 128'(1));
        chk("bp_rd_left", 128'(rd_q.size()), 128'(0));
        // Wrap
        a0 = acc_cnt;
        launch(8'hFE, 9'd4);
        wait_idle(100, 1'b0);
        chk("w_acc", 128'(acc_cnt - a0), 128'(4));
        chk("w_rd_left", 128'(rd_q.size()), 128'(0));
        // Zero count
        r0 = rd_cnt;
        d0 = done_cnt;
        launch(8'h55, 9'd0);
        chk("z_busy", 128'(bus.busy), 128'(1));
        chk("z_done", 128'(bus.done), 128'(1));
        chk("z_cs", 128'(bus.sram_chipselect2), 128'(0));
        tick();
        chk("z_idle", 128'(bus.busy), 128'(0));
        chk("z_done_end", 128'(bus.done), 128'(0));
        chk("z_reads", 128'(rd_cnt - r0), 128'(0));
        chk("z_done_cnt", 128'(done_cnt - d0), 128'(1));
        // Full memory with random ready and ignored start pulses
        a0 = acc_cnt;
        d0 = done_cnt;
        launch(8'h80, 9'd256);
        wait_idle(3000, 1'b1);
        bus.inst_ready = 1'b1;
        chk("f_acc", 128'(acc_cnt - a0), 128'(256));
        chk("f_done", 128'(done_cnt - d0), 128'(1));
        chk("f_acc_left", 128'(acc_q.size()), 128'(0));
        chk("f_rd_left", 128'(rd_q.size()), 128'(0));
        tick(2);
        chk("f_idle", 128'(bus.busy), 128'(0));
        // Reset mid-run: two words queued, one read in flight
        bus.inst_ready = 1'b0;
        launch(8'h30, 9'd8);
        tick(3);
        chk("r_valid_pre", 128'(bus.inst_valid), 128'(1));
        chk("r_head_pre", 128'(bus.inst_addr), 128'(8'h30));
        d0 = done_cnt;
        reset = 1'b1;
        rd_q.delete();
        acc_q.delete();
        tick();
        chk("r_valid", 128'(bus.inst_valid), 128'(0));
        chk("r_busy", 128'(bus.busy), 128'(0));
        chk("r_done", 128'(bus.done), 128'(0));
        reset = 1'b0;
        tick();
        chk("r_no_done", 128'(done_cnt - d0), 128'(0));
        bus.inst_ready = 1'b1;
        a0 = acc_cnt;
        launch(8'h20, 9'd3);
        wait_idle(100, 1'b0);
        chk("r_acc", 128'(acc_cnt - a0), 128'(3));
        chk("r_acc_left", 128'(acc_q.size()), 128'(0));
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
